// File: rtl/bitseq_pkg.sv
// Shared definitions for the bit-sequence scan arbiter: FSM encoding,
// default pattern and requester identifiers.
package bitseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam int                     DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PAT     = 5'b10010;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bitseq_scan_arbiter_detect.sv
// Serial pattern detector: keeps the last PAT_LEN-1 bits and raises a
// registered hit one cycle after the bit that completes PAT.
module bitseq_detect
    import bitseq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT     = DEF_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic hit
);

    logic [PAT_LEN-2:0] hist_r;
    logic [PAT_LEN-1:0] win_s;
    logic               match_s;

    // Candidate window: history plus the bit arriving this cycle.
    always_comb begin
        win_s   = {hist_r, bit_in};
        match_s = bit_valid && (win_s == PAT);
    end

    // History shift and registered hit; cleared at every new grant.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_r <= '0;
            hit    <= 1'b0;
        end else begin
            hit <= match_s;
            if (bit_valid) begin
                hist_r <= win_s[PAT_LEN-2:0];
            end
        end
    end

endmodule

// File: rtl/bitseq_scan_arbiter.sv
// Round-robin arbiter that lends one serial pattern detector to two
// framed requesters and returns a per-frame hit count.
module bitseq_scan_arbiter
    import bitseq_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT     = DEF_PAT,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              res_valid,
    output logic              res_id,
    output logic [CNT_W-1:0]  res_hits,
    output logic              res_overflow,
    output logic              busy
);

    localparam int               BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_r, state_s;
    logic                grant_r, grant_s, ptr_r;
    logic [DATA_W-1:0]   shreg_r, gdata_s;
    logic                last_r, gvalid_s, glast_s;
    logic [BIT_W-1:0]    bcnt_r;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic                ovf_r, ovf_next_s;
    logic                hit_s, start_s, accept_s, shift_done_s;
    logic                bit_valid_s, bit_in_s;
    logic                res_valid_r, res_id_r, res_ovf_r;
    logic [CNT_W-1:0]    res_hits_r;

    // Arbitration, granted-requester mux and handshake qualifiers.
    always_comb begin
        gdata_s  = (grant_r == REQ1) ? req1_data  : req0_data;
        gvalid_s = (grant_r == REQ1) ? req1_valid : req0_valid;
        glast_s  = (grant_r == REQ1) ? req1_last  : req0_last;
        if (req0_valid && req1_valid) begin
            grant_s = ptr_r;
        end else if (req1_valid) begin
            grant_s = REQ1;
        end else begin
            grant_s = REQ0;
        end
        start_s      = (state_r == ST_IDLE) && (req0_valid || req1_valid);
        accept_s     = (state_r == ST_LOAD) && gvalid_s;
        shift_done_s = (state_r == ST_SHIFT) && (bcnt_r == BIT_W'(DATA_W - 1));
        bit_in_s     = shreg_r[DATA_W-1];
    end

    // Saturating hit counter; overflow latches on a hit while already full.
    always_comb begin
        cnt_next_s = cnt_r;
        ovf_next_s = ovf_r;
        if (hit_s && (cnt_r == CNT_MAX)) begin
            ovf_next_s = 1'b1;
        end else if (hit_s) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = start_s ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_s = accept_s ? ST_SHIFT : ST_LOAD;
            ST_SHIFT: begin
                if (shift_done_s) begin
                    state_s = last_r ? ST_FLUSH : ST_LOAD;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_FLUSH:  state_s = ST_RESULT;
            ST_RESULT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        req0_ready  = (state_r == ST_LOAD) && (grant_r == REQ0);
        req1_ready  = (state_r == ST_LOAD) && (grant_r == REQ1);
        busy        = (state_r != ST_IDLE);
        bit_valid_s = (state_r == ST_SHIFT);
    end

    // Grant, word shifter, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r     <= REQ0;
            ptr_r       <= REQ0;
            shreg_r     <= '0;
            last_r      <= 1'b0;
            bcnt_r      <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            res_hits_r  <= '0;
            res_ovf_r   <= 1'b0;
        end else begin
            if (start_s) begin
                grant_r <= grant_s;
                cnt_r   <= '0;
                ovf_r   <= 1'b0;
            end else begin
                cnt_r   <= cnt_next_s;
                ovf_r   <= ovf_next_s;
            end
            if (accept_s) begin
                shreg_r <= gdata_s;
                last_r  <= glast_s;
                bcnt_r  <= '0;
            end else if (bit_valid_s) begin
                shreg_r <= shreg_r << 1;
                bcnt_r  <= bcnt_r + BIT_W'(1);
            end
            // FLUSH is where the final hit lands, so capture the next count.
            res_valid_r <= (state_r == ST_FLUSH);
            if (state_r == ST_FLUSH) begin
                res_id_r   <= grant_r;
                res_hits_r <= cnt_next_s;
                res_ovf_r  <= ovf_next_s;
            end
            if (state_r == ST_RESULT) begin
                ptr_r <= ~grant_r;
            end
        end
    end

    assign res_valid    = res_valid_r;
    assign res_id       = res_id_r;
    assign res_hits     = res_hits_r;
    assign res_overflow = res_ovf_r;

    bitseq_detect #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_s),
        .bit_valid (bit_valid_s),
        .bit_in    (bit_in_s),
        .hit       (hit_s)
    );

endmodule

// File: tb/tb_bitseq_scan_arbiter.sv
// Bench for bitseq_scan_arbiter: two instances (8-bit and 2-bit counters)
// share stimulus; results are predicted from the frame bit streams.
module tb_bitseq_scan_arbiter;

    localparam int         PL = 5;
    localparam logic [4:0] P  = 5'b10010;

    typedef struct {
        int id;
        int hits;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v[2];
    logic       l[2];
    logic [7:0] d[2];

    logic       rdy_a0, rdy_a1, rdy_b0, rdy_b1;
    logic       val_a, id_a, ovf_a, busy_a;
    logic       val_b, id_b, ovf_b, busy_b;
    logic [7:0] hits_a;
    logic [1:0] hits_b;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nres = 0;
    int   owner = -1;
    int   res_log[$];
    int   last_id, last_hits_a, last_hits_b, last_ovf_b;
    exp_t expq[$];
    bit   fb0[$];
    bit   fb1[$];

    always #5 clk = ~clk;

    bitseq_scan_arbiter #(.DATA_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_data(d[0]), .req0_last(l[0]), .req0_ready(rdy_a0),
        .req1_valid(v[1]), .req1_data(d[1]), .req1_last(l[1]), .req1_ready(rdy_a1),
        .res_valid(val_a), .res_id(id_a), .res_hits(hits_a), .res_overflow(ovf_a),
        .busy(busy_a)
    );

    bitseq_scan_arbiter #(.DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_data(d[0]), .req0_last(l[0]), .req0_ready(rdy_b0),
        .req1_valid(v[1]), .req1_data(d[1]), .req1_last(l[1]), .req1_ready(rdy_b1),
        .res_valid(val_b), .res_id(id_b), .res_hits(hits_b), .res_overflow(ovf_b),
        .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r != 0) ? rdy_a1 : rdy_a0;
    endfunction

    // Reference: count overlapping occurrences of P in a frame's bit stream.
    function automatic int count_hits(input bit q[$]);
        int         n;
        logic [4:0] w;
        n = 0;
        for (int i = 0; i + PL <= q.size(); i++) begin
            w = '0;
            for (int k = 0; k < PL; k++) w = {w[3:0], q[i+k]};
            if (w == P) n++;
        end
        return n;
    endfunction

    function automatic void accept_word(input int r, input logic [7:0] w, input logic last);
        int h;
        if (owner == -1) owner = r;
        for (int b = 7; b >= 0; b--) begin
            if (r == 0) fb0.push_back(w[b]);
            else        fb1.push_back(w[b]);
        end
        if (last) begin
            h = (r == 0) ? count_hits(fb0) : count_hits(fb1);
            expq.push_back('{r, h, cyc});
            if (r == 0) fb0.delete();
            else        fb1.delete();
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: scoreboard, grant exclusivity and result checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
                fb0.delete();
                fb1.delete();
                owner = -1;
            end else begin
                if (owner == 0) chk("ready1_while_req0_owns", rdy_a1, 0);
                if (owner == 1) chk("ready0_while_req1_owns", rdy_a0, 0);
                if (v[0] && rdy_a0) accept_word(0, d[0], l[0]);
                if (v[1] && rdy_a1) accept_word(1, d[1], l[1]);
                if (val_a || val_b) begin
                    chk("res_valid_a_vs_b", val_b, val_a);
                    chk("result_was_pending", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("res_id_a", id_a, e.id);
                        chk("res_id_b", id_b, e.id);
                        chk("res_hits_cnt8", hits_a, (e.hits > 255) ? 255 : e.hits);
                        chk("res_ovf_cnt8", ovf_a, e.hits > 255);
                        chk("res_hits_cnt2", hits_b, (e.hits > 3) ? 3 : e.hits);
                        chk("res_ovf_cnt2", ovf_b, e.hits > 3);
                        chk("result_latency", cyc - e.cyc, 10);
                    end
                    res_log.push_back(int'(id_a));
                    last_id     = int'(id_a);
                    last_hits_a = int'(hits_a);
                    last_hits_b = int'(hits_b);
                    last_ovf_b  = int'(ovf_b);
                    owner       = -1;
                    nres++;
                end
            end
        end
    end

    task automatic send_frame(input int r, input int n, input logic [31:0] words, output int first_wait);
        int c;
        first_wait = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            v[r] = 1'b1;
            d[r] = words[31-8*i -: 8];
            l[r] = (i == n - 1);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!rdy(r) && c < 200);
            if (i == 0) first_wait = c;
            chk("word_accepted", rdy(r), 1);
            @(posedge clk);
            #1;
            if (c >= 200) break;
        end
        v[r] = 1'b0;
        l[r] = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int c;
        c = 0;
        while (nres < target && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("result_arrived", nres >= target, 1);
    endtask

    initial begin
        int         fw0, fw1, base, mode, n0, n1;
        logic [31:0] w0, w1;
        v[0] = 1'b0; v[1] = 1'b0; l[0] = 1'b0; l[1] = 1'b0;
        d[0] = 8'h00; d[1] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_ready0", rdy_a0, 0);
        chk("rst_ready1", rdy_a1, 0);
        chk("rst_res_valid", val_a, 0);
        chk("rst_res_id", id_a, 0);
        chk("rst_res_hits", hits_a, 0);
        chk("rst_res_overflow", ovf_a, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send_frame(0, 1, {8'b10010010, 24'h0}, fw0);
        wait_results(1);
        chk("single_word_id", last_id, 0);
        chk("single_word_hits", last_hits_a, 2);

        send_frame(1, 2, {8'b00000100, 8'b10000000, 16'h0}, fw1);
        wait_results(2);
        chk("cross_word_id", last_id, 1);
        chk("cross_word_hits", last_hits_a, 1);

        send_frame(0, 1, {8'b00001001, 24'h0}, fw0);
        wait_results(3);
        chk("frame_a_hits", last_hits_a, 0);
        send_frame(0, 1, 32'h0, fw0);
        wait_results(4);
        chk("no_cross_frame_hits", last_hits_a, 0);

        send_frame(0, 4, {4{8'b10010010}}, fw0);
        wait_results(5);
        chk("saturated_hits_cnt2", last_hits_b, 3);
        chk("saturated_ovf_cnt2", last_ovf_b, 1);

        // Arbitration from reset with both requesters contending.
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = nres;
        w0 = $urandom; w1 = $urandom;
        fork
            begin
                send_frame(0, 1, w0, fw0);
                send_frame(0, 1, w1, fw0);
            end
            begin
                send_frame(1, 1, w1, fw1);
                send_frame(1, 1, w0, fw1);
            end
        join
        wait_results(base + 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (base + i < res_log.size()) ? res_log[base+i] : -1, i % 2);
        end

        send_frame(1, 1, $urandom, fw1);
        chk("req1_alone_grant_wait", fw1, 2);
        wait_results(base + 5);
        chk("req1_alone_id", last_id, 1);

        for (int k = 0; k < 8; k++) begin
            mode = $urandom_range(0, 2);
            n0 = $urandom_range(1, 4);
            n1 = $urandom_range(1, 4);
            w0 = $urandom & 32'hF0F0F0F0 | 32'h09000900;
            w1 = $urandom;
            base = nres;
            if (mode == 2) begin
                fork
                    send_frame(0, n0, w0, fw0);
                    send_frame(1, n1, w1, fw1);
                join
                wait_results(base + 2);
            end else begin
                send_frame(mode, n0, w0, fw0);
                wait_results(base + 1);
            end
        end

        // Leave the pointer at req1, then abort a req1 frame mid-shift.
        send_frame(0, 1, $urandom, fw0);
        wait_results(nres + 1);
        base = nres;
        @(posedge clk);
        #1;
        v[1] = 1'b1; d[1] = 8'hA5; l[1] = 1'b1;
        fw1 = 0;
        do begin
            @(negedge clk);
            fw1++;
        end while (!rdy_a1 && fw1 < 50);
        chk("abort_frame_accepted", rdy_a1, 1);
        @(posedge clk);
        #1;
        v[1] = 1'b0; l[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy_a, 0);
        chk("abort_ready0", rdy_a0, 0);
        chk("abort_ready1", rdy_a1, 0);
        chk("abort_res_valid", val_a, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_no_result", nres, base);

        fork
            send_frame(0, 1, {8'b10010000, 24'h0}, fw0);
            send_frame(1, 1, $urandom, fw1);
        join
        wait_results(base + 2);
        chk("post_abort_first_id", (base < res_log.size()) ? res_log[base] : -1, 0);
        chk("post_abort_order_id", last_id, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
